// File: rtl/mc_alu_if.sv
// Bundle of the mc_alu request/response signals.
// The host drives the request side through the master modport; the ALU is the slave.
interface mc_alu_if #(
   parameter int WIDTH = 8
);
   logic             START;
   logic [WIDTH-1:0] DATA1;
   logic [WIDTH-1:0] DATA2;
   logic [2:0]       SELECT;
   logic [1:0]       RSC;
   logic [WIDTH-1:0] RESULT;
   logic             ZERO;
   logic             CARRY;
   logic             BUSY;
   logic             DONE;

   modport master (
      output START, DATA1, DATA2, SELECT, RSC,
      input  RESULT, ZERO, CARRY, BUSY, DONE
   );

   modport slave (
      input  START, DATA1, DATA2, SELECT, RSC,
      output RESULT, ZERO, CARRY, BUSY, DONE
   );
endinterface

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-step logic/add, shift-and-add multiply, and one-bit-per-step shifts.
// Results, flags and DONE are registered and only updated on the final step of an operation.
module mc_alu #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic     CLK,
   input logic     RESET,
   mc_alu_if.slave bus
);
   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_LSL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;

   state_t           state_r, state_nxt_s;
   logic [2:0]       op_r, op_nxt_s;
   logic [1:0]       rsc_r, rsc_nxt_s;
   logic [WIDTH-1:0] a_r, a_nxt_s;
   logic [WIDTH-1:0] b_r, b_nxt_s;
   logic [WIDTH-1:0] acc_r, acc_nxt_s;
   logic [SHW-1:0]   cnt_r, cnt_nxt_s;
   logic             nz_r, nz_nxt_s;
   logic [WIDTH-1:0] result_r, result_nxt_s;
   logic             zero_r, zero_nxt_s;
   logic             carry_r, carry_nxt_s;
   logic             done_r, done_nxt_s;

   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] mac_s, shl_s, shr_s, fin_s;
   logic [31:0]      n_s, neff_s, steps_s;

   assign sum_s   = {1'b0, a_r} + {1'b0, b_r};
   assign mac_s   = b_r[0] ? (acc_r + a_r) : acc_r;
   assign shl_s   = nz_r ? {a_r[WIDTH-2:0], 1'b0} : a_r;
   assign n_s     = 32'(bus.DATA2);
   assign steps_s = (neff_s == 32'd0) ? 32'd1 : neff_s;

   // Effective shift distance: rotate wraps modulo WIDTH, other shifts saturate at WIDTH.
   always_comb begin
      neff_s = n_s;
      if (bus.SELECT == OP_SHR && bus.RSC == 2'b10) begin
         neff_s = n_s % 32'(WIDTH);
      end else if (n_s > 32'(WIDTH)) begin
         neff_s = 32'(WIDTH);
      end else begin
         neff_s = n_s;
      end
   end

   // One-bit right shift step selected by the latched mode (11 behaves as logical).
   always_comb begin
      shr_s = a_r;
      if (nz_r) begin
         case (rsc_r)
            2'b01:   shr_s = {a_r[WIDTH-1], a_r[WIDTH-1:1]};
            2'b10:   shr_s = {a_r[0], a_r[WIDTH-1:1]};
            default: shr_s = {1'b0, a_r[WIDTH-1:1]};
         endcase
      end else begin
         shr_s = a_r;
      end
   end

   // Value that the final step commits to RESULT.
   always_comb begin
      fin_s = {WIDTH{1'b0}};
      case (op_r)
         OP_FWD:  fin_s = b_r;
         OP_ADD:  fin_s = sum_s[WIDTH-1:0];
         OP_AND:  fin_s = a_r & b_r;
         OP_OR:   fin_s = a_r | b_r;
         OP_MUL:  fin_s = mac_s;
         OP_LSL:  fin_s = shl_s;
         OP_SHR:  fin_s = shr_s;
         default: fin_s = {WIDTH{1'b0}};
      endcase
   end

   // Next-state and datapath update for the IDLE/BUSY controller.
   always_comb begin
      state_nxt_s  = state_r;
      op_nxt_s     = op_r;
      rsc_nxt_s    = rsc_r;
      a_nxt_s      = a_r;
      b_nxt_s      = b_r;
      acc_nxt_s    = acc_r;
      cnt_nxt_s    = cnt_r;
      nz_nxt_s     = nz_r;
      result_nxt_s = result_r;
      zero_nxt_s   = zero_r;
      carry_nxt_s  = carry_r;
      done_nxt_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.START) begin
               state_nxt_s = ST_BUSY;
               op_nxt_s    = bus.SELECT;
               rsc_nxt_s   = bus.RSC;
               a_nxt_s     = bus.DATA1;
               b_nxt_s     = bus.DATA2;
               acc_nxt_s   = {WIDTH{1'b0}};
               // cnt holds the number of steps remaining after the current one
               case (bus.SELECT)
                  OP_MUL: begin
                     cnt_nxt_s = SHW'(WIDTH - 1);
                     nz_nxt_s  = 1'b1;
                  end
                  OP_LSL, OP_SHR: begin
                     cnt_nxt_s = SHW'(steps_s - 32'd1);
                     nz_nxt_s  = (neff_s != 32'd0);
                  end
                  default: begin
                     cnt_nxt_s = {SHW{1'b0}};
                     nz_nxt_s  = 1'b0;
                  end
               endcase
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            case (op_r)
               OP_MUL: begin
                  acc_nxt_s = mac_s;
                  a_nxt_s   = {a_r[WIDTH-2:0], 1'b0};
                  b_nxt_s   = {1'b0, b_r[WIDTH-1:1]};
               end
               OP_LSL:  a_nxt_s = shl_s;
               OP_SHR:  a_nxt_s = shr_s;
               default: a_nxt_s = a_r;
            endcase
            if (cnt_r == {SHW{1'b0}}) begin
               state_nxt_s  = ST_IDLE;
               result_nxt_s = fin_s;
               zero_nxt_s   = (fin_s == {WIDTH{1'b0}});
               carry_nxt_s  = (op_r == OP_ADD) ? sum_s[WIDTH] : 1'b0;
               done_nxt_s   = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r - {{(SHW-1){1'b0}}, 1'b1};
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r  <= ST_IDLE;
         op_r     <= 3'b000;
         rsc_r    <= 2'b00;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         cnt_r    <= {SHW{1'b0}};
         nz_r     <= 1'b0;
         result_r <= {WIDTH{1'b0}};
         zero_r   <= 1'b1;
         carry_r  <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         op_r     <= op_nxt_s;
         rsc_r    <= rsc_nxt_s;
         a_r      <= a_nxt_s;
         b_r      <= b_nxt_s;
         acc_r    <= acc_nxt_s;
         cnt_r    <= cnt_nxt_s;
         nz_r     <= nz_nxt_s;
         result_r <= result_nxt_s;
         zero_r   <= zero_nxt_s;
         carry_r  <= carry_nxt_s;
         done_r   <= done_nxt_s;
      end
   end

   assign bus.RESULT = result_r;
   assign bus.ZERO   = zero_r;
   assign bus.CARRY  = carry_r;
   assign bus.DONE   = done_r;
   assign bus.BUSY   = (state_r == ST_BUSY);
endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu (WIDTH=8): directed vector table, hand-written
// reset/hold sequences, and random operations against an arithmetic reference model.
module tb_mc_alu;
   logic CLK;
   logic RESET;
   int   checks;
   int   failures;

   mc_alu_if #(.WIDTH(8)) bus ();
   mc_alu #(.WIDTH(8)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0] sel;
      logic [1:0] rsc;
      logic [7:0] d1;
      logic [7:0] d2;
      logic [7:0] res;
      logic       zero;
      logic       carry;
      int         lat;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain arithmetic on the whole operands.
   task automatic model(input logic [2:0] sel, input logic [1:0] rsc, input logic [7:0] a,
                        input logic [7:0] b, output logic [7:0] r, output logic c, output int lat);
      int n;
      int ne;
      int p;
      logic [15:0] t;
      n = int'(b);
      c = 1'b0;
      lat = 1;
      r = 8'h00;
      case (sel)
         3'd0: r = b;
         3'd1: begin p = int'(a) + int'(b); r = p[7:0]; c = p[8]; end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: begin p = int'(a) * int'(b); r = p[7:0]; lat = 8; end
         3'd5: begin
            ne = (n > 8) ? 8 : n;
            r = (n >= 8) ? 8'h00 : (a << n);
            lat = (ne == 0) ? 1 : ne;
         end
         3'd6: begin
            if (rsc == 2'b10) begin
               ne = n % 8;
               t = {a, a} >> ne;
               r = t[7:0];
            end else begin
               ne = (n > 8) ? 8 : n;
               if (rsc == 2'b01) r = (ne >= 8) ? {8{a[7]}} : 8'($signed(a) >>> ne);
               else r = (ne >= 8) ? 8'h00 : (a >> ne);
            end
            lat = (ne == 0) ? 1 : ne;
         end
         default: r = 8'h00;
      endcase
   endtask

   // Issue one operation in the current (idle or DONE) cycle and check its completion.
   task automatic run_op(input logic [2:0] sel, input logic [1:0] rsc, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] er, input logic ez,
                         input logic ec, input int el, input bit hold, input string tag);
      int lat;
      bit stable;
      logic [7:0] prev;
      @(negedge CLK);
      bus.START = 1'b1; bus.SELECT = sel; bus.RSC = rsc; bus.DATA1 = d1; bus.DATA2 = d2;
      prev = bus.RESULT;
      @(posedge CLK); #1;
      stable = (bus.RESULT === prev) && (bus.BUSY === 1'b1) && (bus.DONE === 1'b0);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         if (hold) begin
            bus.START  = 1'b1;
            bus.SELECT = 3'($urandom_range(0, 7));
            bus.RSC    = 2'($urandom_range(0, 3));
            bus.DATA1  = 8'($urandom_range(0, 255));
            bus.DATA2  = 8'($urandom_range(0, 255));
         end else begin
            bus.START = 1'b0;
         end
         @(posedge CLK); #1;
         if (bus.DONE === 1'b1) begin
            lat = c;
            break;
         end
         if (bus.RESULT !== prev || bus.BUSY !== 1'b1) stable = 1'b0;
      end
      bus.START = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'(el));
      chk({tag, " result"}, 32'(bus.RESULT), 32'(er));
      chk({tag, " zero"}, 32'(bus.ZERO), 32'(ez));
      chk({tag, " carry"}, 32'(bus.CARRY), 32'(ec));
      chk({tag, " held-while-busy"}, 32'(stable), 32'd1);
      chk({tag, " busy-at-done"}, 32'(bus.BUSY), 32'd0);
   endtask

   task automatic run_rand(input logic [2:0] sel, input logic [1:0] rsc, input logic [7:0] d1,
                           input logic [7:0] d2, input bit hold, input string tag);
      logic [7:0] r;
      logic c;
      int lat;
      model(sel, rsc, d1, d2, r, c, lat);
      run_op(sel, rsc, d1, d2, r, (r == 8'h00), c, lat, hold, tag);
   endtask

   initial begin
      int quiet;
      checks = 0;
      failures = 0;
      vecs[0]  = '{3'd1, 2'b00, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1};
      vecs[1]  = '{3'd4, 2'b00, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 8};
      vecs[2]  = '{3'd4, 2'b00, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 8};
      vecs[3]  = '{3'd6, 2'b00, 8'h96, 8'h03, 8'h12, 1'b0, 1'b0, 3};
      vecs[4]  = '{3'd6, 2'b01, 8'h96, 8'h03, 8'hF2, 1'b0, 1'b0, 3};
      vecs[5]  = '{3'd6, 2'b10, 8'h96, 8'h03, 8'hD2, 1'b0, 1'b0, 3};
      vecs[6]  = '{3'd5, 2'b00, 8'h81, 8'h09, 8'h00, 1'b1, 1'b0, 8};
      vecs[7]  = '{3'd6, 2'b10, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1};
      vecs[8]  = '{3'd6, 2'b01, 8'h80, 8'd200, 8'hFF, 1'b0, 1'b0, 8};
      vecs[9]  = '{3'd0, 2'b00, 8'h33, 8'hA5, 8'hA5, 1'b0, 1'b0, 1};
      vecs[10] = '{3'd2, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
      vecs[11] = '{3'd3, 2'b00, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1};
      vecs[12] = '{3'd1, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1};
      vecs[13] = '{3'd7, 2'b00, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1};
      vecs[14] = '{3'd5, 2'b00, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1};
      vecs[15] = '{3'd6, 2'b11, 8'h81, 8'h01, 8'h40, 1'b0, 1'b0, 1};
      vecs[16] = '{3'd6, 2'b10, 8'h81, 8'h09, 8'hC0, 1'b0, 1'b0, 1};
      vecs[17] = '{3'd5, 2'b00, 8'h03, 8'h07, 8'h80, 1'b0, 1'b0, 7};
      vecs[18] = '{3'd6, 2'b01, 8'h40, 8'h08, 8'h00, 1'b1, 1'b0, 8};
      vecs[19] = '{3'd1, 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1};

      bus.START = 1'b0; bus.SELECT = 3'd0; bus.RSC = 2'b00; bus.DATA1 = 8'h00; bus.DATA2 = 8'h00;
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset result", 32'(bus.RESULT), 32'h0);
      chk("reset zero", 32'(bus.ZERO), 32'h1);
      chk("reset carry", 32'(bus.CARRY), 32'h0);
      chk("reset busy", 32'(bus.BUSY), 32'h0);
      chk("reset done", 32'(bus.DONE), 32'h0);
      @(negedge CLK);
      RESET = 1'b0;

      for (int i = 0; i < 20; i++) begin
         run_op(vecs[i].sel, vecs[i].rsc, vecs[i].d1, vecs[i].d2, vecs[i].res,
                vecs[i].zero, vecs[i].carry, vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
      end

      // START held with changing inputs during a MUL, then an ADD issued in the DONE cycle.
      run_op(3'd4, 2'b00, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 8, 1'b1, "mul-held");
      run_op(3'd1, 2'b00, 8'h05, 8'h06, 8'h0B, 1'b0, 1'b0, 1, 1'b0, "add-after-held");

      // Reset at the fourth step of a MUL aborts it without a DONE pulse.
      run_op(3'd4, 2'b00, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 8, 1'b0, "mul-pre-reset");
      @(negedge CLK);
      bus.START = 1'b1; bus.SELECT = 3'd4; bus.DATA1 = 8'h07; bus.DATA2 = 8'h09;
      @(posedge CLK);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK); #1;
      chk("abort done", 32'(bus.DONE), 32'h0);
      chk("abort result", 32'(bus.RESULT), 32'h0);
      chk("abort zero", 32'(bus.ZERO), 32'h1);
      chk("abort carry", 32'(bus.CARRY), 32'h0);
      chk("abort busy", 32'(bus.BUSY), 32'h0);
      @(posedge CLK); #1;
      chk("start-under-reset busy", 32'(bus.BUSY), 32'h0);
      @(negedge CLK);
      RESET = 1'b0;
      bus.START = 1'b0;
      quiet = 1;
      for (int c = 0; c < 10; c++) begin
         @(posedge CLK); #1;
         if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) quiet = 0;
      end
      chk("no done after abort", 32'(quiet), 32'h1);
      run_op(3'd1, 2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1, 1'b0, "add-after-reset");

      for (int i = 0; i < 120; i++) begin
         logic [2:0] sel;
         logic [7:0] d2;
         sel = 3'($urandom_range(0, 7));
         d2  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
         run_rand(sel, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), d2,
                  ($urandom_range(0, 3) == 0), $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
